// File: rtl/hazard_sequencer.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle MDU occupancy, with a saturating stall counter and a sticky timeout flag.
module hazard_sequencer #(
  parameter int unsigned MDU_TIMEOUT = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        ID_uses_rt,
  input  logic        ID_mdu_op,
  input  logic        IE_memread,
  input  logic [4:0]  IE_rt,
  input  logic        IE_branch_taken,
  input  logic        mdu_done,
  output logic        pc_write,
  output logic        IF_ID_write,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        mdu_start,
  output logic        mdu_error,
  output logic [15:0] stall_cycles
);

  localparam logic S_RUN      = 1'b0;
  localparam logic S_MDU_WAIT = 1'b1;

  localparam logic [7:0] TMO_LAST = 8'(MDU_TIMEOUT - 1);

  logic        r_state;
  logic [7:0]  r_tmo_cnt;
  logic [15:0] r_stall_cnt;
  logic        r_mdu_error;

  logic        w_next_state;
  logic        w_load_use;
  logic        w_tmo_hit;
  logic        w_set_error;

  assign w_load_use = IE_memread && (IE_rt != 5'd0) &&
                      ((IE_rt == ID_rs) || (ID_uses_rt && (IE_rt == ID_rt)));
  assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

  // Outputs are forced low while reset is held, independent of state.
  always_comb begin
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    mdu_start    = 1'b0;
    w_next_state = r_state;
    w_set_error  = 1'b0;
    if (rst_i) begin
      case (r_state)
        S_RUN: begin
          if (IE_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            pc_write     = 1'b1;
            IF_ID_write  = 1'b1;
          end else if (w_load_use) begin
            ID_EX_bubble = 1'b1;
          end else if (ID_mdu_op) begin
            mdu_start    = 1'b1;
            pc_write     = 1'b1;
            IF_ID_write  = 1'b1;
            w_next_state = S_MDU_WAIT;
          end else begin
            pc_write     = 1'b1;
            IF_ID_write  = 1'b1;
          end
        end
        default: begin
          if (mdu_done || w_tmo_hit) begin
            pc_write     = 1'b1;
            IF_ID_write  = 1'b1;
            w_next_state = S_RUN;
            w_set_error  = !mdu_done;
          end else begin
            ID_EX_bubble = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_RUN;
      r_tmo_cnt   <= '0;
      r_stall_cnt <= '0;
      r_mdu_error <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Held at zero throughout RUN, so it is already clear on entry to MDU_WAIT.
      if (r_state == S_RUN)
        r_tmo_cnt <= '0;
      else
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      if (!pc_write && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (w_set_error)
        r_mdu_error <= 1'b1;
    end
  end

  assign mdu_error    = r_mdu_error;
  assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed self-checking bench for hazard_sequencer (MDU_TIMEOUT=8).
module tb_hazard_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  ID_rs, ID_rt, IE_rt;
  logic        ID_uses_rt, ID_mdu_op, IE_memread, IE_branch_taken, mdu_done;
  logic        pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, mdu_start, mdu_error;
  logic [15:0] stall_cycles;

  int n_vec = 0;
  int n_err = 0;

  hazard_sequencer #(.MDU_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_mdu_op(ID_mdu_op),
    .IE_memread(IE_memread), .IE_rt(IE_rt), .IE_branch_taken(IE_branch_taken),
    .mdu_done(mdu_done),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
    .ID_EX_bubble(ID_EX_bubble), .mdu_start(mdu_start), .mdu_error(mdu_error),
    .stall_cycles(stall_cycles)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0; IE_rt = 5'd0;
    ID_uses_rt = 1'b0; ID_mdu_op = 1'b0; IE_memread = 1'b0;
    IE_branch_taken = 1'b0; mdu_done = 1'b0;
  endtask

  // ctrl vector: {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, mdu_start}
  task automatic chk_ctrl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, mdu_start}, {27'd0, exp});
  endtask

  task automatic nxt();
    @(negedge clk_i);
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    #1;
    chk_ctrl("reset_forced", 5'b00000);
    chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
    chk("reset_err", {31'd0, mdu_error}, 32'd0);
    nxt(); nxt();
    rst_i = 1'b1; #1;
    chk_ctrl("release_idle", 5'b11000);
    chk("release_stall", {16'd0, stall_cycles}, 32'd0);

    // load-use via rs
    nxt(); IE_memread = 1'b1; IE_rt = 5'd5; ID_rs = 5'd5; #1;
    chk_ctrl("loaduse_rs", 5'b00010);
    nxt(); idle(); #1;
    chk("loaduse_rs_stall", {16'd0, stall_cycles}, 32'd1);
    chk_ctrl("loaduse_clear", 5'b11000);
    // IE_rt = 0 never stalls
    IE_memread = 1'b1; IE_rt = 5'd0; ID_rs = 5'd0; #1;
    chk_ctrl("loaduse_r0", 5'b11000);
    nxt(); idle(); #1;
    chk("loaduse_r0_stall", {16'd0, stall_cycles}, 32'd1);
    // rt match only counts when ID_uses_rt
    IE_memread = 1'b1; IE_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd3; ID_uses_rt = 1'b0; #1;
    chk_ctrl("rt_unused", 5'b11000);
    ID_uses_rt = 1'b1; #1;
    chk_ctrl("rt_used", 5'b00010);
    nxt(); idle(); #1;
    chk("rt_stall", {16'd0, stall_cycles}, 32'd2);

    // branch beats load-use and MDU op
    IE_branch_taken = 1'b1; IE_memread = 1'b1; IE_rt = 5'd5; ID_rs = 5'd5; ID_mdu_op = 1'b1; #1;
    chk_ctrl("branch_prio", 5'b11110);
    nxt(); idle(); #1;
    chk_ctrl("branch_stays_run", 5'b11000);
    chk("branch_stall", {16'd0, stall_cycles}, 32'd2);

    // MDU normal: done 5 cycles after launch
    ID_mdu_op = 1'b1; #1;
    chk_ctrl("mdu_launch", 5'b11001);
    for (int unsigned k = 1; k <= 4; k++) begin
      nxt();
      IE_branch_taken = (k == 2);
      #1;
      chk_ctrl($sformatf("mdu_wait%0d", k), 5'b00010);
    end
    nxt(); IE_branch_taken = 1'b0; ID_mdu_op = 1'b0; mdu_done = 1'b1; #1;
    chk_ctrl("mdu_done_release", 5'b11000);
    nxt(); idle(); #1;
    chk("mdu_stall", {16'd0, stall_cycles}, 32'd6);
    chk("mdu_err0", {31'd0, mdu_error}, 32'd0);
    chk_ctrl("mdu_back_run", 5'b11000);
    // mdu_done in RUN is ignored
    mdu_done = 1'b1; #1;
    chk_ctrl("done_in_run", 5'b11000);
    nxt(); idle();

    // done coincides with the timeout cycle: done wins
    ID_mdu_op = 1'b1; #1;
    chk_ctrl("tmo_done_launch", 5'b11001);
    nxt(); ID_mdu_op = 1'b0;
    for (int unsigned k = 2; k <= 7; k++) nxt();
    #1;
    chk_ctrl("tmo_done_7th", 5'b00010);
    nxt(); mdu_done = 1'b1; #1;
    chk_ctrl("tmo_done_8th", 5'b11000);
    nxt(); idle(); #1;
    chk("tmo_done_err", {31'd0, mdu_error}, 32'd0);
    chk("tmo_done_stall", {16'd0, stall_cycles}, 32'd13);

    // pure timeout
    ID_mdu_op = 1'b1; #1;
    nxt(); ID_mdu_op = 1'b0;
    for (int unsigned k = 2; k <= 7; k++) nxt();
    #1;
    chk_ctrl("tmo_7th", 5'b00010);
    nxt(); #1;
    chk_ctrl("tmo_release", 5'b11000);
    chk("tmo_err_pre", {31'd0, mdu_error}, 32'd0);
    nxt(); #1;
    chk("tmo_err_set", {31'd0, mdu_error}, 32'd1);
    chk("tmo_stall", {16'd0, stall_cycles}, 32'd20);
    chk_ctrl("tmo_back_run", 5'b11000);
    nxt(); nxt(); nxt(); #1;
    chk("tmo_err_sticky", {31'd0, mdu_error}, 32'd1);

    // reset mid-MDU_WAIT
    ID_mdu_op = 1'b1; #1;
    nxt(); ID_mdu_op = 1'b0;
    nxt(); #1;
    chk_ctrl("pre_reset_wait", 5'b00010);
    rst_i = 1'b0; #1;
    chk_ctrl("midwait_reset_forced", 5'b00000);
    chk("midwait_reset_err", {31'd0, mdu_error}, 32'd0);
    chk("midwait_reset_stall", {16'd0, stall_cycles}, 32'd0);
    nxt(); rst_i = 1'b1; #1;
    chk_ctrl("midwait_run", 5'b11000);

    // saturation under a permanent load-use hazard
    IE_memread = 1'b1; IE_rt = 5'd9; ID_rs = 5'd9;
    repeat (70000) nxt();
    #1;
    chk("sat_value", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk_ctrl("sat_stalling", 5'b00010);
    nxt(); idle(); nxt(); #1;
    chk("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
    chk("sat_err", {31'd0, mdu_error}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline hazard controller sitting beside the forwarding logic in the 5-stage MIPS pipeline. It covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes and multi-cycle multiply/divide (MDU) occupancy. It drives the PC and IF/ID write enables, the IF/ID flush and the ID/EX bubble insert. It also keeps a saturating stall-cycle counter and a sticky MDU timeout flag.

## Interface

Parameters:
- MDU_TIMEOUT, 64: maximum cycles spent in MDU_WAIT before abort; legal range 2..255.

Ports (clock and reset first):
- clk_i  input  1  pipeline clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- ID_rs  input  5  rs field of the instruction in ID.
- ID_rt  input  5  rt field of the instruction in ID.
- ID_uses_rt  input  1  the ID instruction reads rt as a source.
- ID_mdu_op  input  1  the ID instruction is a multi-cycle MDU op.
- IE_memread  input  1  the EX instruction is a load.
- IE_rt  input  5  destination register of the EX instruction.
- IE_branch_taken  input  1  the branch in EX resolved taken.
- mdu_done  input  1  single-cycle pulse from the MDU when its result is ready.
- pc_write  output  1  PC register load enable.
- IF_ID_write  output  1  IF/ID register load enable.
- IF_ID_flush  output  1  zero the IF/ID register.
- ID_EX_bubble  output  1  load a NOP into ID/EX.
- mdu_start  output  1  single-cycle MDU launch pulse.
- mdu_error  output  1  sticky flag: MDU timeout occurred.
- stall_cycles  output  16  saturating count of cycles with pc_write=0.

## Operation

- States: RUN and MDU_WAIT. Encoding is free; reset state is RUN.
- Load-use hazard is defined as: IE_memread && IE_rt!=0 && (IE_rt==ID_rs || (ID_uses_rt && IE_rt==ID_rt)).
- Outputs in RUN are Mealy, evaluated in priority order:
  1. IE_branch_taken: IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, IF_ID_write=1, mdu_start=0. Stay in RUN. Branch wins over a load-use hazard or MDU op in ID.
  2. Load-use hazard: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, mdu_start=0. Stay in RUN. The hazard clears itself once the load advances to MEM.
  3. ID_mdu_op: mdu_start=1, all enables 1, no flush or bubble. Next state is MDU_WAIT.
  4. Otherwise: pc_write=1, IF_ID_write=1, all others 0.
- MDU_WAIT behaviour:
  - While waiting: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0. IE_branch_taken is ignored here because EX holds the MDU op or bubbles.
  - On mdu_done=1: release in that same cycle (pc_write=1, IF_ID_write=1, ID_EX_bubble=0). Next state is RUN.
  - Timeout counter (8 bit) clears on entry to MDU_WAIT and increments each cycle in MDU_WAIT.
  - If the counter equals MDU_TIMEOUT-1 with mdu_done=0: set mdu_error, release as for done, next state RUN.
  - mdu_done in the same cycle as the timeout takes precedence; mdu_error is not set.
- mdu_done received in RUN is ignored.
- mdu_error clears only on reset.
- stall_cycles increments on every clock edge where pc_write=0 and rst_i=1, and saturates at 16'hFFFF.

## Timing

- Reset (rst_i=0), asynchronous: state goes to RUN, timeout counter and stall_cycles to 0, mdu_error to 0. While rst_i=0, outputs are forced: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, mdu_start=0.
- Reset asserted mid-MDU_WAIT aborts immediately to RUN without setting mdu_error. First RUN behaviour applies in the first cycle after rst_i rises.
- Control outputs are combinational from state and inputs, with zero-cycle latency. Only state, the counters and mdu_error are registered.
- An MDU op launched at edge N is waited on from cycle N+1. With mdu_done at cycle N+k, the front end stalls for k-1 cycles and stall_cycles grows by k-1.
- A load-use stall costs exactly 1 cycle per load.
- A branch flush costs 0 stall cycles (pc_write stays 1) and does not count toward stall_cycles.
- mdu_start is never asserted on two consecutive cycles.

## Test plan

- Reset release with idle inputs: pc_write=1, IF_ID_write=1, every other output 0, stall_cycles=0.
- Load-use: IE_memread=1, IE_rt=5, ID_rs=5 for one cycle → pc_write=0, ID_EX_bubble=1 that cycle, stall_cycles=1. Repeat with IE_rt=0 → no stall.
- Branch plus hazard: IE_branch_taken=1 with a load-use match and ID_mdu_op=1 → IF_ID_flush=1, ID_EX_bubble=1, pc_write=1, mdu_start=0, state stays RUN.
- MDU normal: ID_mdu_op pulse, then mdu_done 5 cycles later → mdu_start for exactly 1 cycle, 4 stalled cycles, release in the done cycle, stall_cycles=4, mdu_error=0.
- MDU timeout with MDU_TIMEOUT=8 and no mdu_done → 7 stalled cycles then release, mdu_error=1 and sticky. Repeat with mdu_done on the 8th cycle → mdu_error stays 0.
- Reset mid-MDU_WAIT, then saturation: after the reset, state is RUN and mdu_error=0. Then force a stall for 70000 cycles → stall_cycles holds 16'hFFFF.
